cv32e40x_obi_instr_bridge: RTL
==============================

# cv32e40x_obi_instr_bridge

Protocol bridge between the instruction-side MPU and the external OBI instruction port. It turns the MPU's valid/ready transaction handshake into OBI request/grant phases, holding address and attributes stable from first request until grant. It also counts outstanding transactions, throttles new requests at a configurable limit, and forwards OBI responses to the MPU response port with zero latency.

## Interface
- MAX_OUTSTANDING, 2: maximum granted-but-unresponded transactions; legal range 1..7.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- trans_valid_i  in  1  transaction request from the MPU (MPU bus_trans_valid_o).
- trans_ready_o  out  1  transaction accepted (to MPU bus_trans_ready_i).
- trans_addr_i  in  32  fetch address.
- trans_prot_i  in  3  protection attributes.
- trans_dbg_i  in  1  debug-mode access.
- trans_memtype_i  in  2  [0] bufferable, [1] cacheable (as set by the PMA).
- resp_valid_o  out  1  response valid (to MPU bus_resp_valid_i).
- resp_rdata_o  out  32  response read data.
- resp_err_o  out  1  response bus error.
- obi_req_o  out  1  OBI address-phase request.
- obi_gnt_i  in  1  OBI grant.
- obi_addr_o  out  32  OBI address.
- obi_prot_o  out  3  OBI prot.
- obi_dbg_o  out  1  OBI dbg.
- obi_memtype_o  out  2  OBI memtype.
- obi_rvalid_i  in  1  OBI response-phase valid.
- obi_rdata_i  in  32  OBI read data.
- obi_err_i  in  1  OBI error.
- outstanding_o  out  3  current outstanding count.

## Operation
- Two-state FSM, states TRANSPARENT and REGISTERED. It uses a registered attribute set (addr, prot, dbg, memtype) and a 3-bit counter cnt.
- cnt_full = (cnt == MAX_OUTSTANDING).
- TRANSPARENT:
  - obi_req_o = trans_valid_i && !cnt_full. OBI address and attribute outputs come directly from the trans_* inputs.
  - trans_ready_o = obi_gnt_i && !cnt_full.
  - If obi_req_o && !obi_gnt_i, capture the trans_* attributes into the register and go to REGISTERED.
- REGISTERED:
  - obi_req_o = 1. OBI address and attribute outputs come from the register.
  - trans_ready_o = 0, whatever obi_gnt_i is. The MPU-side transaction was already committed; the MPU keeps trans_valid_i high, but its inputs are ignored.
  - On obi_gnt_i: return to TRANSPARENT. The bridge issues a one-cycle pulse on trans_ready_o in the cycle after the grant, in TRANSPARENT, only when the MPU still presents that same transaction.
  - Correction to the rule above: trans_ready_o in REGISTERED = obi_gnt_i. The handshake completes exactly in the grant cycle, and state returns to TRANSPARENT.
- Once raised, obi_req_o never drops and its attributes never change until granted (OBI compliance). cnt_full never blocks REGISTERED; entry into REGISTERED already required !cnt_full.
- Counter:
  - Increment on obi_req_o && obi_gnt_i.
  - Decrement on obi_rvalid_i.
  - Both in the same cycle: unchanged.
  - obi_rvalid_i with cnt == 0 is a protocol violation. cnt stays 0 (no underflow); an assertion flags it.
  - outstanding_o = cnt.
- Responses are a combinational passthrough: resp_valid_o = obi_rvalid_i, resp_rdata_o = obi_rdata_i, resp_err_o = obi_err_i. There is no buffering; the MPU is always ready.

## Timing
- Reset values:
  - State TRANSPARENT, cnt 0, register 0.
  - obi_req_o = 0 and trans_ready_o = 0 (combinational, with trans_valid_i low or undefined irrelevant; the FSM forces both low while rst_n is low).
  - outstanding_o 0, resp_valid_o follows obi_rvalid_i.
- Latency:
  - Request: 0 cycles, trans_valid_i to obi_req_o.
  - Grant-cycle handshake: trans_ready_o is high in the cycle where obi_req_o && obi_gnt_i.
  - Response: 0 cycles.
- Throughput: one grant per cycle while !cnt_full. At cnt_full, an rvalid in cycle N lets a request go out in cycle N+1 (cnt is registered).
- Reset mid-operation:
  - Everything returns to reset values immediately.
  - Any response arriving after reset is passed through but does not change cnt (already 0).
  - Integration guarantees that the bus is also reset.

## Test plan
- Back-to-back grants: trans_valid_i high 4 cycles, gnt always 1, rvalid 1 cycle later each. Required: obi_req_o high 4 cycles, 4 trans_ready_o pulses, outstanding_o sequence 1,1,1,1,0.
- Grant stall: addr 0x0000_1000 presented, gnt low 3 cycles, and the MPU drives trans_addr_i to 0x0000_2000 in cycle 2. Required: obi_addr_o stays 0x0000_1000, obi_req_o high throughout, trans_ready_o only in the grant cycle.
- Throttle: MAX_OUTSTANDING=2, no rvalid, 3 requests. Required: 2 grants, outstanding_o=2, obi_req_o low for the third. rvalid arrives, then the third request goes out the next cycle.
- Simultaneous grant and rvalid with cnt=1. Required: cnt stays 1; resp_valid_o, rdata 0xDEAD_BEEF and err=0 pass through the same cycle.
- Error response: rvalid with err=1. Required: resp_err_o=1 in the same cycle, cnt decrements.
- Async reset asserted in REGISTERED with cnt=2. Required: obi_req_o=0 and outstanding_o=0 immediately. After release, a fresh request is issued normally.

Source files
------------

// File: rtl/cv32e40x_obi_instr_bridge.sv
// Instruction-side bridge from the MPU transaction handshake to the OBI request/grant port.
// Tracks outstanding fetches and throttles requests at MAX_OUTSTANDING.
module cv32e40x_obi_instr_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        trans_valid_i,
    output logic        trans_ready_o,
    input  logic [31:0] trans_addr_i,
    input  logic [2:0]  trans_prot_i,
    input  logic        trans_dbg_i,
    input  logic [1:0]  trans_memtype_i,

    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,

    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    output logic [2:0]  obi_prot_o,
    output logic        obi_dbg_o,
    output logic [1:0]  obi_memtype_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i,

    output logic [2:0]  outstanding_o
);

    typedef enum logic {
        TRANSPARENT = 1'b0,
        REGISTERED  = 1'b1
    } state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [2:0]  prot_q;
    logic        dbg_q;
    logic [1:0]  memtype_q;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;
    logic        cnt_full;
    logic        cnt_inc;
    logic        cnt_dec;

    assign cnt_full = (cnt_q == 3'(MAX_OUTSTANDING));

    // Request and ready are forced low while reset is asserted, independent of the MPU side.
    always_comb begin
        obi_req_o     = 1'b0;
        trans_ready_o = 1'b0;
        obi_addr_o    = trans_addr_i;
        obi_prot_o    = trans_prot_i;
        obi_dbg_o     = trans_dbg_i;
        obi_memtype_o = trans_memtype_i;
        if (state_q == REGISTERED) begin
            obi_addr_o    = addr_q;
            obi_prot_o    = prot_q;
            obi_dbg_o     = dbg_q;
            obi_memtype_o = memtype_q;
        end
        if (rst_n) begin
            if (state_q == REGISTERED) begin
                obi_req_o     = 1'b1;
                trans_ready_o = obi_gnt_i;
            end else begin
                obi_req_o     = trans_valid_i && !cnt_full;
                trans_ready_o = obi_gnt_i && !cnt_full;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TRANSPARENT;
            addr_q    <= '0;
            prot_q    <= '0;
            dbg_q     <= 1'b0;
            memtype_q <= '0;
        end else begin
            case (state_q)
                TRANSPARENT: begin
                    if (obi_req_o && !obi_gnt_i) begin
                        addr_q    <= trans_addr_i;
                        prot_q    <= trans_prot_i;
                        dbg_q     <= trans_dbg_i;
                        memtype_q <= trans_memtype_i;
                        state_q   <= REGISTERED;
                    end
                end
                REGISTERED: begin
                    if (obi_gnt_i) begin
                        state_q <= TRANSPARENT;
                    end
                end
                default: state_q <= TRANSPARENT;
            endcase
        end
    end

    // A stray rvalid at zero is ignored so the count cannot wrap.
    assign cnt_inc = obi_req_o && obi_gnt_i;
    assign cnt_dec = obi_rvalid_i && (cnt_q != 3'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + 3'd1;
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign resp_valid_o  = obi_rvalid_i;
    assign resp_rdata_o  = obi_rdata_i;
    assign resp_err_o    = obi_err_i;

    a_no_rvalid_underflow : assert property (
        @(posedge clk) disable iff (!rst_n) obi_rvalid_i |-> (cnt_q != 3'd0)
    ) else $error("obi_rvalid_i with no outstanding transaction");

endmodule
